// File: rtl/regfile_mp.sv
// Parametrised NRD-read / NWR-write integer register file with optional
// write-to-read bypass and a per-register pending (scoreboard) bit.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD-1:0]      i_ren,
    input  logic [NRD*AW-1:0]   i_raddr,
    output logic [NRD*XLEN-1:0] o_rdata,
    output logic [NRD-1:0]      o_rvalid,
    output logic [NRD-1:0]      o_busy,
    input  logic [NWR-1:0]      i_wen,
    input  logic [NWR*AW-1:0]   i_waddr,
    input  logic [NWR*XLEN-1:0] i_wdata,
    input  logic                i_claim,
    input  logic [AW-1:0]       i_claim_addr
);

    logic [XLEN-1:0]  regs      [NREGS];
    logic [XLEN-1:0]  regs_next [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic [NREGS-1:0] wr_clear;
    logic [NREGS-1:0] claim_set;
    logic [XLEN-1:0]  rd_data [NRD];
    logic [NRD-1:0]   rd_busy;

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Ascending port order lets the highest-index writer win on a collision.
    always_comb begin
        regs_next = regs;
        wr_clear  = '0;
        for (int w = 0; w < NWR; w++) begin
            if (i_wen[w] && !is_zero_reg(i_waddr[w*AW +: AW])) begin
                regs_next[i_waddr[w*AW +: AW]] = i_wdata[w*XLEN +: XLEN];
                wr_clear[i_waddr[w*AW +: AW]]  = 1'b1;
            end
        end
    end

    // A claim belongs to a newer producer, so it overrides a same-cycle clear.
    always_comb begin
        claim_set = '0;
        if (i_claim && !is_zero_reg(i_claim_addr))
            claim_set[i_claim_addr] = 1'b1;
        pending_next = (pending & ~wr_clear) | claim_set;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = i_raddr[k*AW +: AW];

        always_comb begin
            rd_data[k] = '0;
            rd_busy[k] = 1'b0;
            if (!is_zero_reg(ra)) begin
                if (BYPASS != 0) begin
                    rd_data[k] = regs_next[ra];
                    rd_busy[k] = pending[ra] & ~wr_clear[ra];
                end else begin
                    rd_data[k] = regs[ra];
                    rd_busy[k] = pending[ra];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            regs     <= '{default: '0};
            pending  <= '0;
            o_rdata  <= '0;
            o_rvalid <= '0;
            o_busy   <= '0;
        end else begin
            regs     <= regs_next;
            pending  <= pending_next;
            o_rvalid <= i_ren;
            for (int k = 0; k < NRD; k++) begin
                if (i_ren[k]) begin
                    o_rdata[k*XLEN +: XLEN] <= rd_data[k];
                    o_busy[k]               <= rd_busy[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a reference model pushes the expected
// read results into a queue each cycle, popped after the following edge.
module tb_regfile_mp;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int NRD      = 2;
    localparam int NWR      = 2;
    localparam int BYPASS   = 1;
    localparam int ZERO_REG = 1;
    localparam int AW       = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                rstn;
    logic [NRD-1:0]      i_ren;
    logic [NRD*AW-1:0]   i_raddr;
    logic [NRD*XLEN-1:0] o_rdata;
    logic [NRD-1:0]      o_rvalid;
    logic [NRD-1:0]      o_busy;
    logic [NWR-1:0]      i_wen;
    logic [NWR*AW-1:0]   i_waddr;
    logic [NWR*XLEN-1:0] i_wdata;
    logic                i_claim;
    logic [AW-1:0]       i_claim_addr;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
        .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_ren(i_ren), .i_raddr(i_raddr),
        .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_busy(o_busy),
        .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_claim(i_claim), .i_claim_addr(i_claim_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            valid;
        logic            busy;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t             exp_q [$];
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_pend;
    logic [XLEN-1:0]  last_data [NRD];
    logic             last_busy [NRD];
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv)
            n_pass++;
        else
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    // One clock of stimulus: model predicts, edge happens, outputs are scored.
    task automatic applyStimulus(
        input logic            rst_n,
        input logic [1:0]      ren,
        input logic [AW-1:0]   ra0, input logic [AW-1:0] ra1,
        input logic [1:0]      wen,
        input logic [AW-1:0]   wa0, input logic [XLEN-1:0] wd0,
        input logic [AW-1:0]   wa1, input logic [XLEN-1:0] wd1,
        input logic            claim,
        input logic [AW-1:0]   ca
    );
        logic [XLEN-1:0]  nregs [NREGS];
        logic [NREGS-1:0] clr;
        logic [AW-1:0]    ra [NRD];
        logic [AW-1:0]    wa [NWR];
        logic [XLEN-1:0]  wd [NWR];
        exp_t             e;
        rstn         = rst_n;
        i_ren        = ren;
        i_raddr      = {ra1, ra0};
        i_wen        = wen;
        i_waddr      = {wa1, wa0};
        i_wdata      = {wd1, wd0};
        i_claim      = claim;
        i_claim_addr = ca;
        ra[0] = ra0; ra[1] = ra1;
        wa[0] = wa0; wa[1] = wa1;
        wd[0] = wd0; wd[1] = wd1;

        nregs = m_regs;
        clr   = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wen[w] && !(ZERO_REG != 0 && wa[w] == '0)) begin
                nregs[wa[w]] = wd[w];
                clr[wa[w]]   = 1'b1;
            end
        end

        for (int k = 0; k < NRD; k++) begin
            if (!rst_n) begin
                e = '0;
            end else if (!ren[k]) begin
                e = '{valid: 1'b0, busy: last_busy[k], data: last_data[k]};
            end else if (ZERO_REG != 0 && ra[k] == '0) begin
                e = '{valid: 1'b1, busy: 1'b0, data: '0};
            end else if (BYPASS != 0) begin
                e = '{valid: 1'b1, busy: m_pend[ra[k]] & ~clr[ra[k]], data: nregs[ra[k]]};
            end else begin
                e = '{valid: 1'b1, busy: m_pend[ra[k]], data: m_regs[ra[k]]};
            end
            last_data[k] = e.data;
            last_busy[k] = e.busy;
            exp_q.push_back(e);
        end

        if (!rst_n) begin
            m_regs = '{default: '0};
            m_pend = '0;
        end else begin
            m_regs = nregs;
            m_pend = m_pend & ~clr;
            if (claim && !(ZERO_REG != 0 && ca == '0))
                m_pend[ca] = 1'b1;
        end

        @(posedge clk);
        #1;
        for (int k = 0; k < NRD; k++) begin
            e = exp_q.pop_front();
            checkOutput($sformatf("rvalid[%0d]", k), 64'(o_rvalid[k]), 64'(e.valid));
            checkOutput($sformatf("rdata[%0d]", k), 64'(o_rdata[k*XLEN +: XLEN]), 64'(e.data));
            checkOutput($sformatf("busy[%0d]", k), 64'(o_busy[k]), 64'(e.busy));
        end
    endtask

    task automatic readOnly(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        applyStimulus(1'b1, 2'b11, a0, a1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        m_regs = '{default: '0};
        m_pend = '0;
        for (int k = 0; k < NRD; k++) begin
            last_data[k] = '0;
            last_busy[k] = 1'b0;
        end

        // Reset, then every address on both ports
        applyStimulus(1'b0, 2'b00, '0, '0, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        applyStimulus(1'b0, 2'b11, '0, '0, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        for (int a = 0; a < NREGS; a++)
            readOnly(AW'(a), AW'(NREGS - 1 - a));
        applyStimulus(1'b1, 2'b00, '0, '0, 2'b00, '0, '0, '0, '0, 1'b0, '0);

        // Same-address write collision with bypassed read
        applyStimulus(1'b1, 2'b11, 5, 5, 2'b11, 5, 32'hAAAA_0001, 5, 32'h5555_0002, 1'b0, '0);
        readOnly(5, 5);

        // Register 0 is hardwired: write and claim ignored
        applyStimulus(1'b1, 2'b00, '0, '0, 2'b11, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1'b1, 0);
        readOnly(0, 0);

        // Scoreboard: claim, clear by bypassed write, claim beats write
        applyStimulus(1'b1, 2'b00, '0, '0, 2'b00, '0, '0, '0, '0, 1'b1, 7);
        readOnly(7, 7);
        applyStimulus(1'b1, 2'b11, 7, 7, 2'b01, 7, 32'h0000_1234, '0, '0, 1'b0, '0);
        applyStimulus(1'b1, 2'b01, 7, 7, 2'b10, '0, '0, 7, 32'h0000_5678, 1'b1, 7);
        readOnly(7, 7);

        // Hold behaviour when read enable is low
        applyStimulus(1'b1, 2'b00, '0, '0, 2'b01, 3, 32'hDEAD_BEEF, '0, '0, 1'b0, '0);
        readOnly(3, 3);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 2'b00, 3, 3, 2'b00, '0, '0, '0, '0, 1'b0, '0);

        // Randomised traffic with address collisions
        for (int i = 0; i < 60; i++)
            applyStimulus(1'b1, 2'($urandom_range(0, 3)),
                          AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)),
                          AW'($urandom_range(0, 15)), $urandom,
                          AW'($urandom_range(0, 15)), $urandom,
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));

        // Fill everything, claim 9, then reset in the middle of writes
        for (int a = 0; a < NREGS; a += 2)
            applyStimulus(1'b1, 2'b11, AW'(a), AW'(a + 1), 2'b11,
                          AW'(a), $urandom, AW'(a + 1), $urandom, 1'b0, '0);
        applyStimulus(1'b1, 2'b00, '0, '0, 2'b00, '0, '0, '0, '0, 1'b1, 9);
        readOnly(9, 12);
        applyStimulus(1'b0, 2'b11, 9, 4, 2'b11, 4, 32'hCAFE_0004, 9, 32'hCAFE_0009, 1'b1, 9);
        for (int a = 0; a < NREGS; a++)
            readOnly(AW'(a), AW'(a));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
